// File: rtl/bus_decoder_pkg.sv
// Shared types and default constants for the memory-bus decoder.
// State encoding, default error data and the SoC default region map live here.
package bus_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  localparam int DEF_NUM_SLAVES = 8;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam logic [31:0] DEF_ERROR_DATA = 32'hDEAD_BEEF;

  // Slave 0 is the low 2 GiB, slave 1 a 4 KiB window at 0x8000_0000; the rest are parked.
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_WIDTH-1:0] DEF_SLAVE_BASE =
    {{6{32'hFFFF_FFFF}}, 32'h8000_0000, 32'h0000_0000};
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_WIDTH-1:0] DEF_SLAVE_MASK =
    {{6{32'hFFFF_FFFF}}, 32'hFFFF_F000, 32'h8000_0000};

endpackage

// File: rtl/bus_decoder_region_match.sv
// Combinational priority address matcher over packed base/mask regions.
// The lowest matching slave index wins; sel is one-hot or all zero.
module region_match #(
  parameter int                      NUM_SLAVES = 8,
  parameter int                      ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] sel
);

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                   (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
        hit    = 1'b1;
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_decoder.sv
// Native valid/ready memory-bus decoder: registers each request, forwards it to one
// slave, returns its response, and turns unmapped or timed-out accesses into bus errors.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA = DEF_ERROR_DATA
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_valid,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH/8-1:0]      mem_wstrb,
  output logic                         mem_ready,
  output logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         mem_error,
  output logic [NUM_SLAVES-1:0]        enables,
  output logic [ADDR_WIDTH-1:0]        slv_addr,
  output logic [DATA_WIDTH-1:0]        slv_wdata,
  output logic [DATA_WIDTH/8-1:0]      slv_wstrb,
  input  logic [NUM_SLAVES-1:0]        slv_ready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata,
  output logic                         fault_valid,
  output logic [ADDR_WIDTH-1:0]        fault_addr,
  input  logic                         fault_clear
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_SLAVES-1:0]   en_q, en_d;
  logic                    rdy_q, rdy_d;
  logic                    err_q, err_d;
  logic                    fv_q, fv_d;
  logic [ADDR_WIDTH-1:0]   fa_q, fa_d;

  logic                    dec_hit;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  region_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_match (
    .addr (mem_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // One-hot select makes the read-data mux a plain AND-OR.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_rdata |= slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_ready = |(slv_ready & sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    en_d    = '0;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    fv_d    = fault_clear ? 1'b0 : fv_q;
    fa_d    = fa_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          addr_d = mem_addr;
          if (dec_hit) begin
            sel_d   = dec_sel;
            wdata_d = mem_wdata;
            wstrb_d = mem_wstrb;
            cnt_d   = '0;
            en_d    = dec_sel;
            state_d = ST_ACCESS;
          end else begin
            rdy_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = ERROR_DATA;
            state_d = ST_ERROR;
          end
        end
      end
      ST_ACCESS: begin
        // A ready in the last counted cycle still completes normally.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          rdy_d   = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdy_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERROR_DATA;
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
          en_d  = sel_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        fv_d    = 1'b1;
        fa_d    = addr_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      en_q    <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
    end
  end

  assign mem_ready   = rdy_q;
  assign mem_error   = err_q;
  assign mem_rdata   = rdata_q;
  assign enables     = en_q;
  assign slv_addr    = addr_q;
  assign slv_wdata   = wdata_q;
  assign slv_wstrb   = wstrb_q;
  assign fault_valid = fv_q;
  assign fault_addr  = fa_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Randomized bench for bus_decoder: a cycle-timeline model of each transaction is
// queued by the driver and compared against the DUT on every falling edge.
module tb_bus_decoder;

  localparam int NS = 8;
  localparam int T  = 4;

  localparam logic [31:0] BASE_A [NS] = '{32'h0000_0000, 32'h8000_0000, 32'hC000_0000, 32'hC000_0000,
                                          32'hE000_1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] MASK_A [NS] = '{32'h8000_0000, 32'hFFFF_F000, 32'hF000_0000, 32'hE000_0000,
                                          32'hFFFF_F000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [NS*32-1:0] TB_BASE = {BASE_A[7], BASE_A[6], BASE_A[5], BASE_A[4],
                                          BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]};
  localparam logic [NS*32-1:0] TB_MASK = {MASK_A[7], MASK_A[6], MASK_A[5], MASK_A[4],
                                          MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            mem_valid = 1'b0;
  logic [31:0]     mem_addr = '0;
  logic [31:0]     mem_wdata = '0;
  logic [3:0]      mem_wstrb = '0;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic            mem_error;
  logic [NS-1:0]   enables;
  logic [31:0]     slv_addr;
  logic [31:0]     slv_wdata;
  logic [3:0]      slv_wstrb;
  logic [NS-1:0]   slv_ready = '0;
  logic [NS*32-1:0] slv_rdata = '0;
  logic            fault_valid;
  logic [31:0]     fault_addr;
  logic            fault_clear = 1'b0;

  bus_decoder #(
    .NUM_SLAVES     (NS),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .SLAVE_BASE     (TB_BASE),
    .SLAVE_MASK     (TB_MASK),
    .TIMEOUT_CYCLES (T),
    .ERROR_DATA     (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mem_error   (mem_error),
    .enables     (enables),
    .slv_addr    (slv_addr),
    .slv_wdata   (slv_wdata),
    .slv_wstrb   (slv_wstrb),
    .slv_ready   (slv_ready),
    .slv_rdata   (slv_rdata),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_clear (fault_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0] en;
    logic          rdy;
    logic          err;
    logic [31:0]   rdata;
    logic [31:0]   faddr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } exp_t;

  exp_t        expq [$];
  int          total = 0;
  int          bad = 0;
  bit          chk_on = 1'b0;
  logic        fv_m = 1'b0;
  logic [31:0] fa_m = '0;
  int          en_cycles = 0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK_A[i]) == (BASE_A[i] & MASK_A[i])) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return {1'b0, r[30:0]};
      1: return {20'h80000, r[11:0]};
      2: return {4'hC, r[27:0]};
      3: return {3'b110, r[28:0]};
      4: return {20'hE0001, r[11:0]};
      5: return 32'hFFFF_FFFF;
      default: return r;
    endcase
  endfunction

  // Compare process: one timeline entry per cycle, idle when nothing is queued.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        exp_t e;
        e = '0;
        if (expq.size() > 0) e = expq.pop_front();
        chk("enables", 64'(enables), 64'(e.en));
        chk("mem_ready", 64'(mem_ready), 64'(e.rdy));
        if (e.rdy) begin
          chk("mem_error", 64'(mem_error), 64'(e.err));
          chk("mem_rdata", 64'(mem_rdata), 64'(e.rdata));
          last_rdata = mem_rdata;
        end
        if (e.en != '0) begin
          en_cycles++;
          chk("slv_addr", 64'(slv_addr), 64'(e.addr));
          chk("slv_wdata", 64'(slv_wdata), 64'(e.wdata));
          chk("slv_wstrb", 64'(slv_wstrb), 64'(e.wstrb));
        end
        chk("fault_valid", 64'(fault_valid), 64'(fv_m));
        chk("fault_addr", 64'(fault_addr), 64'(fa_m));
        if (e.rdy && e.err) begin
          fv_m = 1'b1;
          fa_m = e.faddr;
        end else if (fault_clear) begin
          fv_m = 1'b0;
        end
      end
    end
  end

  // Slave latency dly: selected slave raises ready in its (dly+1)-th enabled cycle.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int dly, input bit early, input bit clr_on_err, input bit rnd_clr,
                        input logic [31:0] sd);
    int s, k, n;
    exp_t e;
    logic [NS-1:0] oh, noise;
    s = decode(a);
    oh = '0;
    if (s >= 0) oh[s] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NS; i++) slv_rdata[i*32 +: 32] = (i == s) ? sd : $urandom;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    slv_ready = '0;
    e = '0;
    expq.push_back(e);
    if (s < 0) begin
      k = 0;
      n = 1;
      e.rdy = 1'b1; e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.faddr = a;
      expq.push_back(e);
    end else begin
      k = (dly < T) ? dly + 1 : T;
      n = k + 1;
      for (int j = 1; j <= k; j++) begin
        e = '0;
        e.en = oh; e.addr = a; e.wdata = wd; e.wstrb = ws;
        expq.push_back(e);
      end
      e = '0;
      e.rdy = 1'b1;
      if (dly < T) e.rdata = sd;
      else begin e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.faddr = a; end
      expq.push_back(e);
    end
    for (int j = 1; j <= n; j++) begin
      @(posedge clk); #1;
      if (early && j == 1) mem_valid = 1'b0;
      noise = NS'($urandom);
      slv_ready = noise & ~oh;
      if (s >= 0 && j == dly + 1 && j <= k) slv_ready[s] = 1'b1;
      fault_clear = (j == n && clr_on_err) || (rnd_clr && $urandom_range(0, 7) == 0);
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; slv_ready = '0; fault_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enables", 64'(enables), 64'h0);
    chk("rst_ready", 64'(mem_ready), 64'h0);
    chk("rst_error", 64'(mem_error), 64'h0);
    chk("rst_rdata", 64'(mem_rdata), 64'h0);
    chk("rst_slv_addr", 64'(slv_addr), 64'h0);
    chk("rst_fault_valid", 64'(fault_valid), 64'h0);
    chk("rst_fault_addr", 64'(fault_addr), 64'h0);
    reset = 1'b0;
    chk_on = 1'b1;

    // Read, slave0 one wait state.
    en_cycles = 0;
    do_txn(32'h0000_1000, 32'h0, 4'h0, 1, 0, 0, 0, 32'h1122_3344);
    chk("rd_en_cycles", 64'(en_cycles), 64'd2);
    chk("rd_data", 64'(last_rdata), 64'h1122_3344);

    // Write, slave1 zero wait.
    en_cycles = 0;
    do_txn(32'h8000_0004, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 32'h5555_AAAA);
    chk("wr_en_cycles", 64'(en_cycles), 64'd1);
    chk("wr_data", 64'(last_rdata), 64'h5555_AAAA);

    // Unmapped.
    en_cycles = 0;
    do_txn(32'h9000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 32'h0);
    chk("miss_en_cycles", 64'(en_cycles), 64'd0);
    chk("miss_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
    chk("miss_fault_valid", 64'(fault_valid), 64'h1);
    chk("miss_fault_addr", 64'(fault_addr), 64'h9000_0000);

    // Timeout: slave0 never ready.
    en_cycles = 0;
    do_txn(32'h0000_2000, 32'h0, 4'h0, 1000, 0, 0, 0, 32'h0);
    chk("to_en_cycles", 64'(en_cycles), 64'd4);
    chk("to_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
    chk("to_fault_addr", 64'(fault_addr), 64'h0000_2000);

    // Clear coincident with a new fault: the fault wins.
    do_txn(32'hA000_0000, 32'h0, 4'h0, 0, 0, 1, 0, 32'h0);
    chk("clr_fault_valid", 64'(fault_valid), 64'h1);
    chk("clr_fault_addr", 64'(fault_addr), 64'hA000_0000);
    fault_clear = 1'b1;
    @(posedge clk); #1;
    fault_clear = 1'b0;
    chk("clr_alone", 64'(fault_valid), 64'h0);

    // Ready in the final counted cycle still completes.
    do_txn(32'hC000_0040, 32'h1234_5678, 4'h3, T - 1, 0, 0, 0, 32'h0BAD_CAFE);
    chk("late_ready_data", 64'(last_rdata), 64'h0BAD_CAFE);

    // Asynchronous reset during ACCESS.
    chk_on = 1'b0;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 32'h0000_3000; mem_wstrb = 4'h0; slv_ready = '0;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_enables", 64'(enables), 64'h01);
    #2 reset = 1'b1;
    #1;
    chk("arst_enables", 64'(enables), 64'h0);
    chk("arst_ready", 64'(mem_ready), 64'h0);
    chk("arst_fault_valid", 64'(fault_valid), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_no_resp", 64'(mem_ready), 64'h0);
    reset = 1'b0;
    expq.delete();
    fv_m = 1'b0;
    fa_m = '0;
    chk_on = 1'b1;
    do_txn(32'h8000_0010, 32'h0, 4'h0, 2, 0, 0, 0, 32'h7777_0001);
    chk("post_rst_data", 64'(last_rdata), 64'h7777_0001);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic [3:0]  ws;
      a  = rand_addr();
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      do_txn(a, $urandom, ws, $urandom_range(0, 5), $urandom_range(0, 2) == 0, 0, 1, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk); #1;
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
